// File: rtl/dest_pipe_hazard.sv
// Purpose : carries decoded register fields of the ID instruction through ID/EX, EX/MEM and MEM/WB; detects load-use hazards.
// Latency : ID fields appear on IDEX_* after 1 cycle, MemDest/MEM_RegWrite after 2, WriteBackDest/RegWriteWB after 3; Stall is combinational.
// Backpressure: Stall holds PC and IF/ID for one cycle and a bubble enters ID/EX; Flush overrides Stall and also inserts a bubble.
//
// Ports:
//   clk, rst_n                      pipeline clock, asynchronous active-low reset
//   ID_Rs, ID_Rt, ID_Dest           register fields of the instruction in ID
//   ID_RegWrite, ID_MemRead         ID instruction writes the register file / is a load
//   ID_Valid, Flush                 ID holds a real instruction / squash the ID instruction
//   Stall                           hold PC and IF/ID this cycle
//   IDEX_Rs, IDEX_Rt                source fields in EX (forwarding unit)
//   MemDest, MEM_RegWrite           EX/MEM destination and write enable
//   WriteBackDest, RegWriteWB       MEM/WB destination and write enable
//   StallCount                      saturating stall-cycle counter
//
// Build option: define STALL_COUNT_EN to build the stall counter; otherwise StallCount is tied to 0.

module dest_pipe_hazard #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] ID_Rs,
    input  logic [REG_W-1:0] ID_Rt,
    input  logic [REG_W-1:0] ID_Dest,
    input  logic             ID_RegWrite,
    input  logic             ID_MemRead,
    input  logic             ID_Valid,
    input  logic             Flush,
    output logic             Stall,
    output logic [REG_W-1:0] IDEX_Rs,
    output logic [REG_W-1:0] IDEX_Rt,
    output logic [REG_W-1:0] MemDest,
    output logic             MEM_RegWrite,
    output logic [REG_W-1:0] WriteBackDest,
    output logic             RegWriteWB,
    output logic [CNT_W-1:0] StallCount
);

    typedef struct packed {
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] dest;
        logic             regWrite;
        logic             memRead;
    } idExT;

    typedef struct packed {
        logic [REG_W-1:0] dest;
        logic             regWrite;
    } wbInfoT;

    idExT   idEx;
    wbInfoT exMem;
    wbInfoT memWb;
    idExT   idNext;
    logic   loadUse;

    // Only a load sitting in EX cannot be forwarded in time; later producers
    // are covered by forwarding from EX/MEM or MEM/WB. Register 0 never hazards.
    always_comb begin
        loadUse = idEx.memRead && idEx.regWrite && (idEx.dest != '0) &&
                  ((idEx.dest == ID_Rs) || (idEx.dest == ID_Rt));
        Stall   = !Flush && ID_Valid && loadUse;
    end

    always_comb begin
        idNext = '0;
        if (!Stall && !Flush && ID_Valid) begin
            idNext.rs       = ID_Rs;
            idNext.rt       = ID_Rt;
            idNext.dest     = ID_Dest;
            idNext.regWrite = ID_RegWrite;
            idNext.memRead  = ID_MemRead;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idEx  <= '0;
            exMem <= '0;
            memWb <= '0;
        end else begin
            idEx           <= idNext;
            exMem.dest     <= idEx.dest;
            exMem.regWrite <= idEx.regWrite;
            memWb          <= exMem;
        end
    end

    assign IDEX_Rs       = idEx.rs;
    assign IDEX_Rt       = idEx.rt;
    assign MemDest       = exMem.dest;
    assign MEM_RegWrite  = exMem.regWrite;
    assign WriteBackDest = memWb.dest;
    assign RegWriteWB    = memWb.regWrite;

`ifdef STALL_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stallCnt;

    // Saturates rather than wraps so a long-running count never reads as small.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt <= '0;
        end else if (Stall && (stallCnt != CNT_MAX)) begin
            stallCnt <= stallCnt + CNT_ONE;
        end
    end

    assign StallCount = stallCnt;
`else
    assign StallCount = '0;
`endif

endmodule

// File: tb/tb_dest_pipe_hazard.sv
// Purpose : self-checking bench for dest_pipe_hazard using a delay-line reference model.
// Latency : model outputs lag the accepted ID entry by 1/2/3 cycles.
// Backpressure: stalls are predicted from the load-use rule and held ID inputs are replayed.

module tb_dest_pipe_hazard;

    localparam int REG_W = 5;
    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] dest;
        logic             rw;
        logic             mr;
    } entT;

    logic             clk;
    logic             rst_n;
    logic [REG_W-1:0] ID_Rs, ID_Rt, ID_Dest;
    logic             ID_RegWrite, ID_MemRead, ID_Valid, Flush;
    logic             Stall;
    logic [REG_W-1:0] IDEX_Rs, IDEX_Rt, MemDest, WriteBackDest;
    logic             MEM_RegWrite, RegWriteWB;
    logic [CNT_W-1:0] StallCount;

    int nChecks = 0;
    int nFail   = 0;

    // hist[0] = MEM/WB content, hist[1] = EX/MEM, hist[2] = ID/EX
    entT hist[$];
    int  modelCnt;

    dest_pipe_hazard #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Dest(ID_Dest),
        .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
        .ID_Valid(ID_Valid), .Flush(Flush),
        .Stall(Stall), .IDEX_Rs(IDEX_Rs), .IDEX_Rt(IDEX_Rt),
        .MemDest(MemDest), .MEM_RegWrite(MEM_RegWrite),
        .WriteBackDest(WriteBackDest), .RegWriteWB(RegWriteWB),
        .StallCount(StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int expCount();
`ifdef STALL_COUNT_EN
        return modelCnt;
`else
        return 0;
`endif
    endfunction

    function automatic logic modelStall();
        entT ex;
        ex = hist[2];
        return !Flush && ID_Valid && ex.mr && ex.rw && (ex.dest != 0) &&
               (ex.dest == ID_Rs || ex.dest == ID_Rt);
    endfunction

    task automatic modelClear();
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back('0);
        modelCnt = 0;
    endtask

    task automatic setId(input logic v, input int rs, input int rt, input int dest,
                         input logic rw, input logic mr, input logic fl);
        ID_Valid    = v;
        ID_Rs       = REG_W'(rs);
        ID_Rt       = REG_W'(rt);
        ID_Dest     = REG_W'(dest);
        ID_RegWrite = rw;
        ID_MemRead  = mr;
        Flush       = fl;
    endtask

    // Advance one clock: predict what enters ID/EX, then shift the delay line.
    task automatic cycle();
        logic st;
        entT  nx;
        st = modelStall();
        nx = '0;
        if (!st && !Flush && ID_Valid) nx = '{ID_Rs, ID_Rt, ID_Dest, ID_RegWrite, ID_MemRead};
        if (st && modelCnt < CNT_MAX) modelCnt++;
        @(posedge clk);
        #1;
        hist.push_back(nx);
        void'(hist.pop_front());
    endtask

    task automatic applyReset();
        setId(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        modelClear();
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        setId(1'b1, 7, 9, 11, 1'b1, 1'b1, 1'b0);
        cycle();
        setId(1'b1, 11, 3, 4, 1'b1, 1'b0, 1'b0);
        cycle();
        cycle();
        #2 rst_n = 1'b0;
        modelClear();
        #1;
        nChecks++;
        if ({IDEX_Rs, IDEX_Rt, MemDest, MEM_RegWrite, WriteBackDest, RegWriteWB} !== '0) begin
            nFail++;
            $display("FAIL reset_outputs: got %h %h %h %b %h %b, want all 0",
                     IDEX_Rs, IDEX_Rt, MemDest, MEM_RegWrite, WriteBackDest, RegWriteWB);
        end
        nChecks++;
        if (Stall !== 1'b0 || StallCount !== '0) begin
            nFail++;
            $display("FAIL reset_stall: Stall=%b StallCount=%0d, want 0/0", Stall, StallCount);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
    endtask

    task automatic test_propagation();
        applyReset();
        setId(1'b1, 1, 2, 3, 1'b1, 1'b0, 1'b0);
        #1;
        nChecks++;
        if (Stall !== 1'b0) begin nFail++; $display("FAIL prop_stall: Stall=%b want 0", Stall); end
        cycle();
        setId(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        nChecks++;
        if (IDEX_Rs !== 5'd1 || IDEX_Rt !== 5'd2) begin
            nFail++; $display("FAIL prop_idex: Rs=%0d Rt=%0d want 1/2", IDEX_Rs, IDEX_Rt);
        end
        cycle();
        nChecks++;
        if (MemDest !== 5'd3 || MEM_RegWrite !== 1'b1) begin
            nFail++; $display("FAIL prop_mem: dest=%0d rw=%b want 3/1", MemDest, MEM_RegWrite);
        end
        cycle();
        nChecks++;
        if (WriteBackDest !== 5'd3 || RegWriteWB !== 1'b1 || MemDest !== 5'd0) begin
            nFail++;
            $display("FAIL prop_wb: wb=%0d rw=%b mem=%0d want 3/1/0", WriteBackDest, RegWriteWB, MemDest);
        end
    endtask

    task automatic test_load_use();
        applyReset();
        setId(1'b1, 1, 0, 5, 1'b1, 1'b1, 1'b0);
        cycle();
        setId(1'b1, 5, 6, 7, 1'b1, 1'b0, 1'b0);
        #1;
        nChecks++;
        if (Stall !== 1'b1) begin nFail++; $display("FAIL lu_stall: Stall=%b want 1", Stall); end
        cycle();
        nChecks++;
        if (IDEX_Rs !== 5'd0 || MemDest !== 5'd5 || MEM_RegWrite !== 1'b1) begin
            nFail++;
            $display("FAIL lu_bubble: IDEX_Rs=%0d MemDest=%0d rw=%b want 0/5/1", IDEX_Rs, MemDest, MEM_RegWrite);
        end
        nChecks++;
        if (Stall !== 1'b0) begin nFail++; $display("FAIL lu_one_cycle: Stall=%b want 0", Stall); end
        cycle();
        setId(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        nChecks++;
        if (IDEX_Rs !== 5'd5 || IDEX_Rt !== 5'd6 || WriteBackDest !== 5'd5 || RegWriteWB !== 1'b1) begin
            nFail++;
            $display("FAIL lu_resume: IDEX=%0d/%0d WB=%0d/%b want 5/6/5/1", IDEX_Rs, IDEX_Rt, WriteBackDest, RegWriteWB);
        end
        nChecks++;
        if (int'(StallCount) !== expCount() || expCount() > 1) begin
            nFail++; $display("FAIL lu_count: StallCount=%0d want %0d", StallCount, expCount());
        end
    endtask

    task automatic test_reg_zero();
        applyReset();
        setId(1'b1, 2, 3, 0, 1'b1, 1'b1, 1'b0);
        cycle();
        setId(1'b1, 0, 0, 8, 1'b1, 1'b0, 1'b0);
        #1;
        nChecks++;
        if (Stall !== 1'b0) begin nFail++; $display("FAIL reg_zero: Stall=%b want 0", Stall); end
        cycle();
        nChecks++;
        if (IDEX_Rs !== 5'd0 || ({IDEX_Rt, MEM_RegWrite} !== {5'd0, 1'b1})) begin
            nFail++; $display("FAIL reg_zero_flow: IDEX_Rt=%0d MEM_RegWrite=%b want 0/1", IDEX_Rt, MEM_RegWrite);
        end
    endtask

    task automatic test_flush();
        applyReset();
        setId(1'b1, 1, 2, 5, 1'b1, 1'b1, 1'b0);
        cycle();
        setId(1'b1, 5, 5, 9, 1'b1, 1'b0, 1'b1);
        #1;
        nChecks++;
        if (Stall !== 1'b0) begin nFail++; $display("FAIL flush_stall: Stall=%b want 0", Stall); end
        cycle();
        setId(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        nChecks++;
        if (IDEX_Rs !== 5'd0 || IDEX_Rt !== 5'd0 || MemDest !== 5'd5) begin
            nFail++; $display("FAIL flush_bubble: IDEX=%0d/%0d MemDest=%0d want 0/0/5", IDEX_Rs, IDEX_Rt, MemDest);
        end
        cycle();
        nChecks++;
        if (MemDest !== 5'd0 || MEM_RegWrite !== 1'b0) begin
            nFail++; $display("FAIL flush_drop: MemDest=%0d rw=%b want 0/0", MemDest, MEM_RegWrite);
        end
    endtask

    task automatic test_saturation();
        applyReset();
        for (int p = 0; p < 4; p++) begin
            setId(1'b1, 3, 4, 5, 1'b1, 1'b1, 1'b0);
            cycle();
            setId(1'b1, 1, 5, 6, 1'b1, 1'b0, 1'b0);
            cycle();
            cycle();
            setId(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
            nChecks++;
`ifdef STALL_COUNT_EN
            if (int'(StallCount) !== ((p + 1 > 3) ? 3 : p + 1)) begin
                nFail++; $display("FAIL sat_count[%0d]: StallCount=%0d want %0d", p, StallCount, (p + 1 > 3) ? 3 : p + 1);
            end
`else
            if (StallCount !== '0) begin
                nFail++; $display("FAIL sat_count[%0d]: StallCount=%0d want 0", p, StallCount);
            end
`endif
        end
    endtask

    task automatic test_random();
        entT e;
        applyReset();
        for (int i = 0; i < 400; i++) begin
            // Small register range so dependences and load-use pairs occur often.
            setId($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), 1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0);
            #1;
            nChecks++;
            if (Stall !== modelStall()) begin
                nFail++; $display("FAIL rand_stall[%0d]: Stall=%b want %b", i, Stall, modelStall());
            end
            cycle();
            e = hist[2];
            nChecks++;
            if (IDEX_Rs !== e.rs || IDEX_Rt !== e.rt) begin
                nFail++; $display("FAIL rand_idex[%0d]: %0d/%0d want %0d/%0d", i, IDEX_Rs, IDEX_Rt, e.rs, e.rt);
            end
            nChecks++;
            if (MemDest !== hist[1].dest || MEM_RegWrite !== hist[1].rw ||
                WriteBackDest !== hist[0].dest || RegWriteWB !== hist[0].rw) begin
                nFail++;
                $display("FAIL rand_dest[%0d]: mem %0d/%b wb %0d/%b want %0d/%b %0d/%b", i, MemDest, MEM_RegWrite,
                         WriteBackDest, RegWriteWB, hist[1].dest, hist[1].rw, hist[0].dest, hist[0].rw);
            end
            nChecks++;
            if (int'(StallCount) !== expCount()) begin
                nFail++; $display("FAIL rand_count[%0d]: %0d want %0d", i, StallCount, expCount());
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        setId(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        modelClear();
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        test_reset();
        test_propagation();
        test_load_use();
        test_reg_zero();
        test_flush();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
